// File: rtl/sync_fifo_pkg.sv
// Purpose: shared constants and helpers for the sync_fifo block.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package sync_fifo_pkg;

    localparam int DEPTH_FIFO_DEF = 16;
    localparam int DATA_WIDTH_DEF = 8;

    // Bits needed to hold values 0..n-1, never less than 1 so a
    // two-entry FIFO still gets a real pointer bit.
    function automatic int width_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Pointer advance with an explicit wrap compare so depths that are not
    // a power of two wrap at the right place instead of at 2**width.
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Purpose: register-array storage, one sync write port, one registered read port.
// Latency: write visible to a read on the next edge; read data valid 1 cycle after rd_en.
// Backpressure: none; the caller only issues legal addresses/enables. rd_data holds when idle.
// Ports: clk, reset (sync, active-low, clears rd_data only), wr_en/wr_addr/wr_data,
//        rd_en/rd_addr, rd_data (registered).
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH      = DEPTH_FIFO_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_W     = width_for(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately left out of reset; stale words are unreachable
    // once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Purpose: single-clock FIFO of DEPTH_FIFO words of DATA_WIDTH bits.
// Latency: write-to-flag 1 edge; read data on output_data 1 cycle after an accepted read.
// Backpressure: writes dropped while full, reads dropped while empty; no acknowledge.
// Ports: clk, reset (sync, active-low), wr_en, rd_en, input_data,
//        empty, full (decoded from registered count), output_data (registered).
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH_FIFO = DEPTH_FIFO_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic                  empty,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] output_data
);

    localparam int PTR_W = width_for(DEPTH_FIFO);
    localparam int CNT_W = $clog2(DEPTH_FIFO + 1);

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;
    logic             wr_acc;
    logic             rd_acc;
    logic             mem_we;

    // Both requests are judged against the flags before the edge, so a
    // full FIFO takes only the read and an empty one only the write.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Keep storage untouched during reset so requests in a reset cycle
    // have no effect at all.
    assign mem_we = wr_acc && reset;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH_FIFO));

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= PTR_W'(ptr_inc(int'(wptr), DEPTH_FIFO));
            end
            if (rd_acc) begin
                rptr <= PTR_W'(ptr_inc(int'(rptr), DEPTH_FIFO));
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    sync_fifo_mem #(
        .DEPTH      (DEPTH_FIFO),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (mem_we),
        .wr_addr (wptr),
        .wr_data (input_data),
        .rd_en   (rd_acc),
        .rd_addr (rptr),
        .rd_data (output_data)
    );

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] input_data = 8'h00;
    logic       empty;
    logic       full;
    logic [7:0] output_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo #(.DEPTH_FIFO(16), .DATA_WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .input_data  (input_data),
        .empty       (empty),
        .full        (full),
        .output_data (output_data)
    );

    // One clock with the given requests, then back to idle; returns 1 time
    // unit after the edge so outputs are sampled away from it.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        wr_en = w;
        rd_en = r;
        input_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        wr_en = 1'b1;
        rd_en = 1'b1;
        input_data = 8'h5A;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
        n_checks++;
        if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
        n_checks++;
        if (output_data !== 8'h00) begin n_fail++; $display("FAIL reset_out got %h want 00", output_data); end
        cyc(1'b0, 1'b0, 8'h00);
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_no_write got empty=%b want 1", empty); end
    endtask

    task automatic test_fill_drain;
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            n_checks++;
            if (full !== (i == 16)) begin n_fail++; $display("FAIL fill_full[%0d] got %b want %b", i, full, (i == 16)); end
            n_checks++;
            if (empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty[%0d] got %b want 0", i, empty); end
        end
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            n_checks++;
            if (output_data !== 8'(i)) begin n_fail++; $display("FAIL drain_out[%0d] got %h want %h", i, output_data, 8'(i)); end
            n_checks++;
            if (empty !== (i == 16)) begin n_fail++; $display("FAIL drain_empty[%0d] got %b want %b", i, empty, (i == 16)); end
            n_checks++;
            if (full !== 1'b0) begin n_fail++; $display("FAIL drain_full[%0d] got %b want 0", i, full); end
        end
    endtask

    task automatic test_overflow_underflow;
        for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, 8'(i));
        cyc(1'b1, 1'b0, 8'hAA);
        n_checks++;
        if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b want 1", full); end
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            n_checks++;
            if (output_data !== 8'(i)) begin n_fail++; $display("FAIL ovf_drain[%0d] got %h want %h", i, output_data, 8'(i)); end
        end
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty got %b want 1", empty); end
        cyc(1'b0, 1'b1, 8'h00);
        n_checks++;
        if (output_data !== 8'h10) begin n_fail++; $display("FAIL udf_out got %h want 10", output_data); end
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL udf_empty got %b want 1", empty); end
    endtask

    task automatic test_simultaneous;
        logic [7:0] exp3 [3];
        exp3[0] = 8'h22; exp3[1] = 8'h33; exp3[2] = 8'h44;
        // Partially filled: both accepted, read returns the oldest word.
        cyc(1'b1, 1'b0, 8'h11);
        cyc(1'b1, 1'b0, 8'h22);
        cyc(1'b1, 1'b0, 8'h33);
        cyc(1'b1, 1'b1, 8'h44);
        n_checks++;
        if (output_data !== 8'h11) begin n_fail++; $display("FAIL simrw_out got %h want 11", output_data); end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            n_checks++;
            if (output_data !== exp3[i]) begin n_fail++; $display("FAIL simrw_rd[%0d] got %h want %h", i, output_data, exp3[i]); end
        end
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL simrw_empty got %b want 1 (count not 3)", empty); end
        // Full: only the read goes through, 0x55 never stored.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h80 + i));
        cyc(1'b1, 1'b1, 8'h55);
        n_checks++;
        if (output_data !== 8'h80) begin n_fail++; $display("FAIL simfull_out got %h want 80", output_data); end
        n_checks++;
        if (full !== 1'b0) begin n_fail++; $display("FAIL simfull_full got %b want 0", full); end
        for (int i = 1; i < 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            n_checks++;
            if (output_data !== 8'(8'h80 + i)) begin n_fail++; $display("FAIL simfull_rd[%0d] got %h want %h", i, output_data, 8'(8'h80 + i)); end
        end
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL simfull_empty got %b want 1", empty); end
        // Empty: only the write goes through, no bypass to the output.
        cyc(1'b1, 1'b1, 8'h66);
        n_checks++;
        if (output_data !== 8'h8F) begin n_fail++; $display("FAIL simempty_out got %h want 8f", output_data); end
        n_checks++;
        if (empty !== 1'b0) begin n_fail++; $display("FAIL simempty_empty got %b want 0", empty); end
        cyc(1'b0, 1'b1, 8'h00);
        n_checks++;
        if (output_data !== 8'h66) begin n_fail++; $display("FAIL simempty_rd got %h want 66", output_data); end
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL simempty_after got %b want 1", empty); end
    endtask

    task automatic test_wrap_random;
        logic [7:0] sb [$];
        logic [7:0] exp_rd;
        logic [7:0] d;
        logic       w;
        logic       r;
        int         cnt;
        int         writes;
        exp_rd = output_data;
        cnt = 0;
        writes = 0;
        for (int c = 0; c < 300; c++) begin
            // Alternate write-heavy and read-heavy phases so the FIFO
            // swings between near-full and near-empty.
            if ((c / 40) % 2 == 0) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            w = w && (cnt != 16);
            r = r && (cnt != 0);
            d = 8'($urandom_range(0, 255));
            if (r) exp_rd = sb.pop_front();
            if (w) begin sb.push_back(d); writes++; end
            cnt = cnt + (w ? 1 : 0) - (r ? 1 : 0);
            cyc(w, r, d);
            n_checks++;
            if (output_data !== exp_rd) begin n_fail++; $display("FAIL wrap_out[%0d] got %h want %h", c, output_data, exp_rd); end
            n_checks++;
            if (empty !== (cnt == 0)) begin n_fail++; $display("FAIL wrap_empty[%0d] got %b want %b", c, empty, (cnt == 0)); end
            n_checks++;
            if (full !== (cnt == 16)) begin n_fail++; $display("FAIL wrap_full[%0d] got %b want %b", c, full, (cnt == 16)); end
        end
        while (cnt > 0) begin
            exp_rd = sb.pop_front();
            cnt--;
            cyc(1'b0, 1'b1, 8'h00);
            n_checks++;
            if (output_data !== exp_rd) begin n_fail++; $display("FAIL wrap_drain got %h want %h", output_data, exp_rd); end
        end
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_final_empty got %b want 1", empty); end
        n_checks++;
        if (writes < 48) begin n_fail++; $display("FAIL wrap_coverage got %0d writes want >= 48", writes); end
    endtask

    task automatic test_reset_mid;
        for (int i = 1; i <= 6; i++) cyc(1'b1, 1'b0, 8'(8'hA0 + i));
        cyc(1'b0, 1'b1, 8'h00);
        n_checks++;
        if (output_data !== 8'hA1) begin n_fail++; $display("FAIL rstmid_pre got %h want a1", output_data); end
        reset = 1'b0;
        wr_en = 1'b1;
        rd_en = 1'b1;
        input_data = 8'hEE;
        @(posedge clk);
        #1;
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_empty got %b want 1", empty); end
        n_checks++;
        if (output_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_out got %h want 00", output_data); end
        cyc(1'b1, 1'b0, 8'hB1);
        cyc(1'b1, 1'b0, 8'hB2);
        cyc(1'b0, 1'b1, 8'h00);
        n_checks++;
        if (output_data !== 8'hB1) begin n_fail++; $display("FAIL rstmid_rd0 got %h want b1", output_data); end
        cyc(1'b0, 1'b1, 8'h00);
        n_checks++;
        if (output_data !== 8'hB2) begin n_fail++; $display("FAIL rstmid_rd1 got %h want b2", output_data); end
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_final_empty got %b want 1", empty); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow_underflow();
        test_simultaneous();
        test_wrap_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
